receiver_buffer: RTL

//  Receive-side counterpart of the CPU's byte-serializing send path. Collects bytes from
//  the UART receiver and packs every 4 into one 32-bit word, first byte into [31:23+1].

---
 rtl/recv_buffer_pkg.sv | 15 +
 rtl/recv_word_fifo.sv | 76 +++++++
 rtl/receiver_buffer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/recv_buffer_pkg.sv
// Shared widths and the assembler state type for the receive buffer.
package recv_buffer_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    GOT1,
    GOT2,
    GOT3
  } assy_state_t;

endpackage

// File: rtl/recv_word_fifo.sv
// Synchronous first-word-fall-through word FIFO; dout reads 0 while empty and
// drop pulses for a push that finds no room.
module recv_word_fifo #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    do_push  = push && (!full || do_pop);
    drop     = push && full && !do_pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count gates visibility, so stale entries never reach dout.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/receiver_buffer.sv
// Packs UART bytes MSB-first into 32-bit words and queues them for the CPU.
// Define RECV_TIMEOUT_EN to discard partial words after an inter-byte timeout.
module receiver_buffer
  import recv_buffer_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              read,
  input  logic              clear_err,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              full,
  output logic              overflow,
  output logic              timeout_err
);

  localparam int SHIFT_W = (BYTES_PER_WORD - 1) * BYTE_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("receiver_buffer: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 2");
  end

  assy_state_t        state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               overflow_q, overflow_d;
  logic               push;
  logic [WORD_W-1:0]  push_word;
  logic               fifo_empty;
  logic               fifo_drop;
  logic               timeout_hit;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    push      = 1'b0;
    push_word = {shift_q, rx_data};

    if (rx_valid) begin
      shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], rx_data};
      unique case (state_q)
        IDLE: state_d = GOT1;
        GOT1: state_d = GOT2;
        GOT2: state_d = GOT3;
        GOT3: begin
          state_d = IDLE;
          push    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = IDLE;
    end
  end

  // A set event in the same cycle as clear_err must win, so clear first, then set.
  always_comb begin
    overflow_d = clear_err ? 1'b0 : overflow_q;
    if (fifo_drop) overflow_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef RECV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  // The counter only runs while a word is partially assembled; any byte restarts it.
  always_comb begin
    tmo_cnt_d   = '0;
    timeout_hit = 1'b0;
    if (!rx_valid && state_q != IDLE) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_hit = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
    timeout_err_d = clear_err ? 1'b0 : timeout_err_q;
    if (timeout_hit) timeout_err_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  recv_word_fifo #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (push),
    .pop   (read),
    .din   (push_word),
    .dout  (out_data),
    .empty (fifo_empty),
    .full  (full),
    .drop  (fifo_drop)
  );

  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;

endmodule
